fifo_async_wr_side: RTL
=======================

// Module: fifo_async_wr_side
// PURPOSE
//  Write-side (enqueue-domain) half of a dual-clock FIFO.
//  - Owns the write pointer and issues write strobes to a shared dual-port RAM.
//  - Publishes a Gray-coded write pointer to the dequeue domain.
//  - Synchronises the dequeue domain's Gray read pointer into enq_clk and derives full / almost_full / level.
//  - Pairs with a matching read-side block clocked on deq_clk; together they form a full CDC-safe FIFO.
// PARAMETERS
//  data_size    8   width of enq_data / mem_wdata (>=1)
//  addr_size    3   RAM address width; depth = 2**addr_size (>=1)
//  sync_stages  2   flops in the rd_ptr_gray synchroniser (>=2)
//  afull_level  6   almost_full asserts when level >= afull_level (1..depth)
// PORTS
//  enq_clk      in   1            write-domain clock
//  rst_n        in   1            reset, asynchronous, active-low
//  enq_data     in   data_size    data to enqueue
//  enq_valid    in   1            producer offers enq_data
//  enq_ready    out  1            block can accept this cycle
//  flush        in   1            synchronous clear of write side
//  rd_ptr_gray  in   addr_size+1  Gray read pointer from deq domain (async)
//  wr_ptr_gray  out  addr_size+1  registered Gray write pointer to deq domain
//  mem_we       out  1            RAM write enable
//  mem_waddr    out  addr_size    RAM write address
//  mem_wdata    out  data_size    RAM write data
//  full         out  1            level == depth
//  almost_full  out  1            level >= afull_level
//  wr_level     out  addr_size+1  occupancy seen from write side
//  ptr_err      out  1            sticky: synced read pointer ahead of write pointer
// BEHAVIOUR
//  Reset (rst_n=0, async):
//  - wr_bin, wr_ptr_gray and all sync flops = 0.
//  - ptr_err = 0.
//  - Outputs: enq_ready=1 (after release), full=0, almost_full=0, wr_level=0, mem_we=0.
//  Push:
//  - push = enq_valid & enq_ready; enq_ready = !full & !flush.
//  - mem_we = push (combinational); mem_waddr = wr_bin[addr_size-1:0]; mem_wdata = enq_data.
//  - On push, wr_bin <= wr_bin+1, modulo 2**(addr_size+1).
//  - Wrap: the extra MSB toggles each time the address wraps; no other special case.
//  - wr_ptr_gray <= next_bin ^ (next_bin>>1), registered in the same edge. Never combinational.
//  - The Gray pointer changes at most 1 bit per cycle.
//  Synchroniser:
//  - rd_ptr_gray passes through sync_stages flops, then Gray->binary gives rd_bin_s.
//  - A pop in the deq domain becomes visible in wr_level/full after sync_stages enq_clk edges plus deq->enq skew.
//  - full is therefore pessimistic (may lag a pop); it never under-reports.
//  Derived status (combinational from registered state):
//  - wr_level = wr_bin - rd_bin_s, modulo 2**(addr_size+1).
//  - full = (wr_level == 2**addr_size); equivalently, wr_ptr_gray equals the synced pointer with its top 2 bits inverted.
//  - almost_full = (wr_level >= afull_level).
//  ptr_err:
//  - Set when wr_level > 2**addr_size (corrupt/incoherent pointer).
//  - Sticky; cleared only by reset or flush.
//  - Push stays blocked while wr_level > depth.
//  Flush (synchronous, level):
//  - While flush=1: enq_ready=0, mem_we=0.
//  - On each flush edge: wr_bin=0, wr_ptr_gray=0, sync flops=0, ptr_err=0.
//  - The deq side must clear its read pointer in the same flush window.
//  - First push is permitted the cycle after flush deasserts.
//  Simultaneous events:
//  - flush beats push.
//  - A push and a synced pop in the same cycle: level is unchanged, full is recomputed.
//  - Reset mid-burst: the in-flight write is dropped and mem_we is forced 0 immediately.
// TESTING (addr_size=3, sync_stages=2, afull_level=6)
//  T1 reset, 8 pushes, rd_ptr_gray held 0
//     -> mem_waddr 0..7, wr_ptr_gray 0,1,3,2,6,7,5,4,
//     -> almost_full rises after push 6; full=1 and enq_ready=0 after push 8.
//  T2 from full, drive rd_ptr_gray=4'b0001 (1 pop)
//     -> full stays 1 for 2 edges, then full=0, wr_level=7.
//  T3 push 20 with consumer mirroring pointer
//     -> wr_bin wraps 15->0; wr_ptr_gray 4'b1000->4'b0000; mem_waddr wraps 7->0.
//  T4 full and flush=1 with enq_valid=1
//     -> mem_we=0; next cycle wr_ptr_gray=0, wr_level=0, full=0.
//  T5 rd_ptr_gray jumps to bin 5 while wr_bin=2
//     -> ptr_err=1 after sync, enq_ready=0; ptr_err held until flush.
//  T6 assert rst_n=0 during a burst
//     -> mem_we drops immediately; all outputs at reset values.

Source files
------------

// File: rtl/fifo_async_wr_side.sv
// Enqueue-domain half of a dual-clock FIFO: owns the write pointer, drives the shared RAM
// write port, publishes a Gray write pointer and tracks occupancy against a synced read pointer.
module fifo_async_wr_side #(
    parameter int unsigned DataSize   = 8,
    parameter int unsigned AddrSize   = 3,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned AfullLevel = 6
) (
    input  logic                enq_clk,
    input  logic                rst_n,
    input  logic [DataSize-1:0] enq_data_i,
    input  logic                enq_valid_i,
    output logic                enq_ready_o,
    input  logic                flush_i,
    input  logic [AddrSize:0]   rd_ptr_gray_i,
    output logic [AddrSize:0]   wr_ptr_gray_o,
    output logic                mem_we_o,
    output logic [AddrSize-1:0] mem_waddr_o,
    output logic [DataSize-1:0] mem_wdata_o,
    output logic                full_o,
    output logic                almost_full_o,
    output logic [AddrSize:0]   wr_level_o,
    output logic                ptr_err_o
);

    localparam int unsigned PtrW = AddrSize + 1;
    localparam logic [PtrW-1:0] DepthP = PtrW'(2 ** AddrSize);
    localparam logic [PtrW-1:0] AfullP = PtrW'(AfullLevel);

    function automatic logic [PtrW-1:0] gray2bin(input logic [PtrW-1:0] g);
        logic [PtrW-1:0] b;
        b[PtrW-1] = g[PtrW-1];
        for (int i = int'(PtrW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PtrW-1:0] wr_bin_q, wr_bin_d;
    logic [PtrW-1:0] wr_gray_q, wr_gray_d;
    logic [PtrW-1:0] sync_q [SyncStages];
    logic            ptr_err_q, ptr_err_d;
    logic            active_q;

    logic [PtrW-1:0] rd_bin_s;
    logic [PtrW-1:0] level;
    logic            full;
    logic            overflow;
    logic            ready;
    logic            push;

    // active_q is cleared asynchronously so a write in flight is dropped the instant reset hits,
    // and acceptance resumes on the first edge after release.
    always_ff @(posedge enq_clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    always_ff @(posedge enq_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            ptr_err_q <= 1'b0;
        end else if (flush_i) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            ptr_err_q <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            ptr_err_q <= ptr_err_d;
        end
    end

    always_ff @(posedge enq_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SyncStages); i++) begin
                sync_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < int'(SyncStages); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rd_ptr_gray_i;
            for (int i = 1; i < int'(SyncStages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        rd_bin_s = gray2bin(sync_q[SyncStages-1]);
        level    = wr_bin_q - rd_bin_s;
        full     = (level == DepthP);
        // A level beyond depth means the two pointers disagree; refuse writes until flushed.
        overflow = (level > DepthP);
        ready    = active_q & ~flush_i & ~full & ~overflow;
        push     = enq_valid_i & ready;
    end

    always_comb begin
        wr_bin_d  = push ? wr_bin_q + PtrW'(1) : wr_bin_q;
        wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
        ptr_err_d = ptr_err_q | overflow;
    end

    always_comb begin
        enq_ready_o   = ready;
        mem_we_o      = push;
        mem_waddr_o   = wr_bin_q[AddrSize-1:0];
        mem_wdata_o   = enq_data_i;
        wr_ptr_gray_o = wr_gray_q;
        full_o        = full;
        almost_full_o = (level >= AfullP);
        wr_level_o    = level;
        ptr_err_o     = ptr_err_q;
    end

    a_no_write_when_full: assert property (
        @(posedge enq_clk) disable iff (!rst_n) mem_we_o |-> !full_o
    );

    a_gray_single_step: assert property (
        @(posedge enq_clk) disable iff (!rst_n) !flush_i |-> $onehot0(wr_gray_d ^ wr_gray_q)
    );

endmodule
